// File: rtl/ms_timer_pkg.sv
// Shared constants and types for the multi-channel ms timer: register map,
// CTRL bit positions and the alarm channel state encoding.
package ms_timer_pkg;

    localparam logic [5:0] ADDR_CNT     = 6'd0;
    localparam logic [5:0] ADDR_STATUS  = 6'd1;
    localparam logic [5:0] ADDR_IRQ_EN  = 6'd2;
    localparam logic [5:0] ADDR_DIV     = 6'd3;
    localparam logic [5:0] CH_BASE      = 6'd8;
    localparam logic [5:0] CH_STRIDE    = 6'd4;

    localparam logic [1:0] OFF_RELOAD   = 2'd0;
    localparam logic [1:0] OFF_CTRL     = 2'd1;
    localparam logic [1:0] OFF_REMAIN   = 2'd2;

    localparam int CTRL_RUN      = 0;
    localparam int CTRL_PERIODIC = 1;

    typedef logic [0:0] chan_state_t;
    localparam chan_state_t IDLE  = 1'b0;
    localparam chan_state_t ARMED = 1'b1;

endpackage

// File: rtl/ms_timer_multi_if.sv
// IO-bus slave port of the ms timer: strobe/write qualified word access with
// a combinational ack and same-cycle read data.
interface ms_timer_multi_if;
    logic        stb;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;

    modport master (output stb, we, addr, data_in, input data_out, ack);
    modport slave  (input stb, we, addr, data_in, output data_out, ack);
endinterface

// File: rtl/ms_timer_chan.sv
// One down-counting alarm channel: RELOAD, RUN/PERIODIC control, REMAIN and
// the IDLE/ARMED state, emitting a one-clk expire pulse on the expiring tick.
module ms_timer_chan
    import ms_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             reload_we,
    input  logic             ctrl_we,
    input  logic [CNT_W-1:0] wdata,
    input  logic             wr_run,
    input  logic             wr_periodic,
    output logic [CNT_W-1:0] reload,
    output logic [CNT_W-1:0] remain,
    output logic             run,
    output logic             periodic,
    output logic             expire
);

    chan_state_t      state;
    logic [CNT_W-1:0] reload_nz;

    // A zero reload still has to count one tick, otherwise the channel would never expire.
    assign reload_nz = (reload == '0) ? CNT_W'(1) : reload;
    assign run       = (state == ARMED);
    assign expire    = (state == ARMED) && tick && !ctrl_we && (remain <= CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload   <= '0;
            remain   <= '0;
            periodic <= 1'b0;
            state    <= IDLE;
        end else begin
            if (reload_we) begin
                reload <= wdata;
            end
            // A CTRL write beats a coincident tick; that tick is lost for this channel.
            if (ctrl_we) begin
                periodic <= wr_periodic;
                if (wr_run) begin
                    state  <= ARMED;
                    remain <= reload_nz;
                end else begin
                    state  <= IDLE;
                end
            end else if (state == ARMED && tick) begin
                if (remain > CNT_W'(1)) begin
                    remain <= remain - CNT_W'(1);
                end else if (periodic) begin
                    remain <= reload_nz;
                end else begin
                    remain <= '0;
                    state  <= IDLE;
                end
            end
        end
    end

endmodule

// File: rtl/ms_timer_multi.sv
// Multi-channel ms timer: prescaler, tick counter, NUM_CH alarm channels on the IO bus.
// Define MS_TIMER_DIV_WR_EN to make the prescaler divider writable at address 3.
module ms_timer_multi
    import ms_timer_pkg::*;
#(
    parameter int CLOCK_FREQ = 40_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int DIV_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    ms_timer_multi_if.slave   bus,
    output logic              tick,
    output logic [NUM_CH-1:0] ch_irq,
    output logic              irq
);

    localparam int             DIV0   = CLOCK_FREQ / TICK_HZ;
    localparam logic [DIV_W:0] DIV0_V = (DIV_W+1)'(DIV0);

    logic              wr;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W:0]    div_val;
    logic [DIV_W:0]    div_last;
    logic              div_wr;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] flags;
    logic [NUM_CH-1:0] irq_en;
    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] run_v;
    logic [NUM_CH-1:0] periodic_v;
    logic [CNT_W-1:0]  reload_v [NUM_CH];
    logic [CNT_W-1:0]  remain_v [NUM_CH];
    logic [5:0]        ch_rel;
    logic [3:0]        ch_idx;
    logic [1:0]        ch_off;
    logic              ch_hit;
    logic [31:0]       rdata;

    assign wr = bus.stb & bus.we;

`ifdef MS_TIMER_DIV_WR_EN
    logic [DIV_W:0] div_q;

    assign div_wr  = wr && (bus.addr == ADDR_DIV);
    assign div_val = div_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= DIV0_V;
        end else if (div_wr) begin
            div_q <= {1'b0, bus.data_in[DIV_W-1:0]};
        end
    end
`else
    assign div_wr  = 1'b0;
    assign div_val = DIV0_V;
`endif

    // The divider is one bit wider than div_cnt so DIV0 == 2^DIV_W is representable.
    assign div_last = (div_val == '0) ? '0 : div_val - (DIV_W+1)'(1);
    assign tick     = ({1'b0, div_cnt} == div_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (div_wr || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            flags  <= '0;
            irq_en <= '0;
        end else begin
            if (wr && bus.addr == ADDR_CNT) begin
                cnt_q <= bus.data_in[CNT_W-1:0];
            end else if (tick) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // Expiry is OR-ed in after the W1C mask so a coincident set wins.
            flags <= (flags & ~((wr && bus.addr == ADDR_STATUS) ? bus.data_in[NUM_CH-1:0] : '0))
                     | expire;
            if (wr && bus.addr == ADDR_IRQ_EN) begin
                irq_en <= bus.data_in[NUM_CH-1:0];
            end
        end
    end

    assign ch_rel = bus.addr - CH_BASE;
    assign ch_idx = 4'(ch_rel / CH_STRIDE);
    assign ch_off = 2'(ch_rel % CH_STRIDE);
    assign ch_hit = (bus.addr >= CH_BASE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        assign ch_sel[g] = ch_hit && (ch_idx == 4'(g));

        ms_timer_chan #(.CNT_W(CNT_W)) u_chan (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .reload_we   (wr && ch_sel[g] && ch_off == OFF_RELOAD),
            .ctrl_we     (wr && ch_sel[g] && ch_off == OFF_CTRL),
            .wdata       (bus.data_in[CNT_W-1:0]),
            .wr_run      (bus.data_in[CTRL_RUN]),
            .wr_periodic (bus.data_in[CTRL_PERIODIC]),
            .reload      (reload_v[g]),
            .remain      (remain_v[g]),
            .run         (run_v[g]),
            .periodic    (periodic_v[g]),
            .expire      (expire[g])
        );
    end

    always_comb begin
        rdata = '0;
        if (bus.stb) begin
            case (bus.addr)
                ADDR_CNT:    rdata = 32'(cnt_q);
                ADDR_STATUS: rdata = 32'(flags);
                ADDR_IRQ_EN: rdata = 32'(irq_en);
                ADDR_DIV:    rdata = 32'(div_val);
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_sel[i]) begin
                            case (ch_off)
                                OFF_RELOAD: rdata = 32'(reload_v[i]);
                                OFF_CTRL:   rdata = 32'({periodic_v[i], run_v[i]});
                                OFF_REMAIN: rdata = 32'(remain_v[i]);
                                default:    rdata = '0;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign bus.data_out = rdata;
    assign bus.ack      = bus.stb;
    assign ch_irq       = flags & irq_en;
    assign irq          = |ch_irq;

endmodule

// File: tb/tb_ms_timer_multi.sv
// Self-checking bench for ms_timer_multi: directed scenarios followed by random
// bus traffic, all checked every cycle against a tick-level behavioural model.
module tb_ms_timer_multi;
    import ms_timer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] ch_irq;
    logic       irq;
    int         total = 0;
    int         bad = 0;

    ms_timer_multi_if bus_if ();

    ms_timer_multi #(
        .CLOCK_FREQ (10000),
        .TICK_HZ    (1000),
        .NUM_CH     (4),
        .CNT_W      (32),
        .DIV_W      (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_if),
        .tick   (tick),
        .ch_irq (ch_irq),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Reference model: timer state in terms of clocks-since-restart and ticks left.
    int unsigned m_phase;
    int unsigned m_div;
    logic [31:0] m_cnt;
    logic [3:0]  m_flags;
    logic [3:0]  m_irqen;
    logic [31:0] m_reload [4];
    logic [31:0] m_remain [4];
    logic        m_run [4];
    logic        m_per [4];

    function automatic int unsigned eff_div();
        return (m_div == 0) ? 1 : m_div;
    endfunction

    function automatic logic m_tick();
        return (m_phase % eff_div()) == eff_div() - 1;
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] a);
        int rel;
        case (a)
            6'd0: return m_cnt;
            6'd1: return {28'd0, m_flags};
            6'd2: return {28'd0, m_irqen};
            6'd3: return m_div;
            default: begin
                if (a < 6'd8) return 32'd0;
                rel = int'(a) - 8;
                if (rel / 4 >= 4) return 32'd0;
                case (rel % 4)
                    0: return m_reload[rel/4];
                    1: return {30'd0, m_per[rel/4], m_run[rel/4]};
                    2: return m_remain[rel/4];
                    default: return 32'd0;
                endcase
            end
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_div   = 10;
        m_cnt   = 0;
        m_flags = 0;
        m_irqen = 0;
        for (int i = 0; i < 4; i++) begin
            m_reload[i] = 0;
            m_remain[i] = 0;
            m_run[i]    = 0;
            m_per[i]    = 0;
        end
    endtask

    task automatic model_step(input logic s, input logic w, input logic [5:0] a, input logic [31:0] d);
        logic       tk;
        logic       wr;
        logic [3:0] fired;
        tk    = m_tick();
        wr    = s & w;
        fired = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (wr && int'(a) == 9 + 4*i) begin
                m_per[i] = d[1];
                if (d[0]) begin
                    m_run[i]    = 1'b1;
                    m_remain[i] = (m_reload[i] == 0) ? 32'd1 : m_reload[i];
                end else begin
                    m_run[i] = 1'b0;
                end
            end else if (m_run[i] && tk) begin
                if (m_remain[i] > 1) begin
                    m_remain[i] = m_remain[i] - 1;
                end else begin
                    fired[i] = 1'b1;
                    if (m_per[i]) begin
                        m_remain[i] = (m_reload[i] == 0) ? 32'd1 : m_reload[i];
                    end else begin
                        m_remain[i] = 0;
                        m_run[i]    = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (wr && int'(a) == 8 + 4*i) m_reload[i] = d;
        end
        if (wr && a == 6'd0) m_cnt = d;
        else if (tk) m_cnt = m_cnt + 1;
        if (wr && a == 6'd1) m_flags = m_flags & ~d[3:0];
        m_flags = m_flags | fired;
        if (wr && a == 6'd2) m_irqen = d[3:0];
`ifdef MS_TIMER_DIV_WR_EN
        if (wr && a == 6'd3) begin
            m_div   = int'(d[15:0]);
            m_phase = 0;
        end else
`endif
        m_phase = tk ? 0 : m_phase + 1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive just after the edge, check at the falling edge, advance the model.
    task automatic apply_stimulus(input logic s, input logic w, input logic [5:0] a, input logic [31:0] d);
        bus_if.stb     = s;
        bus_if.we      = w;
        bus_if.addr    = a;
        bus_if.data_in = d;
        @(negedge clk);
        check_output("tick", 32'(tick), 32'(m_tick()));
        check_output("ch_irq", 32'(ch_irq), 32'(m_flags & m_irqen));
        check_output("irq", 32'(irq), 32'(|(m_flags & m_irqen)));
        check_output("ack", 32'(bus_if.ack), 32'(s));
        check_output($sformatf("data_out@%0d", a), bus_if.data_out, s ? m_read(a) : 32'd0);
        @(posedge clk);
        model_step(s, w, a, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 6'd0, 32'd0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        apply_stimulus(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [5:0] a);
        apply_stimulus(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic wait_tick_cycle();
        for (int k = 0; k < 64 && !m_tick(); k++) idle(1);
    endtask

    task automatic reset_read(input logic [5:0] a, input logic [31:0] exp, input string tag);
        bus_if.stb  = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.addr = a;
        #1;
        check_output(tag, bus_if.data_out, exp);
    endtask

    initial begin
        int r;
        logic [5:0] a;
        rst            = 1'b0;
        bus_if.stb     = 1'b0;
        bus_if.we      = 1'b0;
        bus_if.addr    = '0;
        bus_if.data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_tick", 32'(tick), 32'd0);
        check_output("rst_irq", 32'(irq), 32'd0);
        check_output("rst_ch_irq", 32'(ch_irq), 32'd0);
        check_output("rst_data_out", bus_if.data_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Free-running prescaler: first tick in cycle 10, CNT=10 after 100 clks.
        idle(100);
        rd(ADDR_CNT);
        rd(ADDR_DIV);

        // CH0 one-shot, reload 3, with interrupt enabled.
        wr(ADDR_IRQ_EN, 32'h1);
        wr(6'd8, 32'd3);
        wr(6'd9, 32'b01);
        idle(35);
        rd(ADDR_STATUS);
        rd(6'd10);
        rd(6'd9);
        wr(ADDR_STATUS, 32'h1);
        idle(2);

        // CH1 periodic, reload 2, then reload 5 mid-run.
        wr(ADDR_IRQ_EN, 32'h3);
        wr(6'd12, 32'd2);
        wr(6'd13, 32'b11);
        for (int k = 0; k < 6; k++) begin
            idle(18);
            rd(6'd14);
            wr(ADDR_STATUS, 32'h2);
        end
        wr(6'd12, 32'd5);
        for (int k = 0; k < 4; k++) begin
            idle(24);
            rd(6'd14);
            wr(ADDR_STATUS, 32'h2);
        end
        wr(6'd13, 32'b00);
        rd(6'd13);

        // W1C of flag2 in the very cycle CH2 expires.
        wr(6'd16, 32'd1);
        wr(6'd17, 32'b01);
        wait_tick_cycle();
        wr(ADDR_STATUS, 32'h4);
        rd(ADDR_STATUS);

        // CNT write coincident with a tick, then wrap on the next tick.
        wait_tick_cycle();
        wr(ADDR_CNT, 32'hFFFF_FFFF);
        rd(ADDR_CNT);
        wait_tick_cycle();
        idle(1);
        rd(ADDR_CNT);

        // Asynchronous reset mid-count with CH3 armed and interrupting.
        wr(ADDR_IRQ_EN, 32'hF);
        wr(6'd20, 32'd2);
        wr(6'd21, 32'b11);
        idle(25);
        rd(ADDR_STATUS);
        rst = 1'b0;
        #1;
        check_output("arst_ch_irq", 32'(ch_irq), 32'd0);
        check_output("arst_irq", 32'(irq), 32'd0);
        reset_read(ADDR_CNT, 32'd0, "arst_cnt");
        reset_read(ADDR_STATUS, 32'd0, "arst_status");
        reset_read(ADDR_IRQ_EN, 32'd0, "arst_irq_en");
        reset_read(6'd21, 32'd0, "arst_ctrl3");
        reset_read(6'd22, 32'd0, "arst_remain3");
        reset_read(6'd20, 32'd0, "arst_reload3");
        model_reset();
        bus_if.stb = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(12);
        rd(6'd22);

        // Divider write: effective only when the feature is built in.
        idle(3);
        wr(ADDR_DIV, 32'd4);
        idle(13);
        rd(ADDR_DIV);

        // Random traffic against the model.
        for (int n = 0; n < 500; n++) begin
            r = int'($urandom_range(0, 11));
            a = 6'(8 + 4 * $urandom_range(0, 3));
            case (r)
                0, 1, 2, 3: idle(1);
                4, 5:       rd(6'($urandom_range(0, 63)));
                6:          wr(a + 6'd1, 32'($urandom_range(0, 3)));
                7:          wr(a, 32'($urandom_range(0, 4)));
                8:          wr(ADDR_STATUS, 32'($urandom_range(0, 15)));
                9:          wr(ADDR_IRQ_EN, 32'($urandom_range(0, 15)));
                10:         wr(ADDR_CNT, $urandom());
                default:    wr(ADDR_DIV, 32'($urandom_range(0, 5)));
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ms_timer_multi.md
Name: ms_timer_multi

Overview:
- Parametrised successor of the single free-running ms counter: a programmable tick prescaler, a loadable CNT_W-bit tick counter and NUM_CH independent down-counting alarm channels.
- Each channel runs one-shot or periodic and raises a sticky expiry flag with a maskable interrupt.
- Sits on the processor IO bus as a single-cycle-ack slave, next to the other system peripherals.
- Its tick output feeds the RTS scheduler.

Parameters:
- CLOCK_FREQ, 40_000_000, system clock in Hz.
- TICK_HZ, 1000, tick rate. Reset divider DIV0 = CLOCK_FREQ/TICK_HZ; must be ≤ 2^DIV_W.
- NUM_CH, 4, alarm channels, 1..8.
- CNT_W, 32, width of tick counter and channel reload/remain registers, 8..32.
- DIV_W, 16, prescaler width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stb  in  1  bus strobe for this block.
- we  in  1  write enable, qualified by stb.
- addr  in  6  word address.
- data_in  in  32  write data.
- data_out  out  32  read data; 0 when stb=0.
- ack  out  1  = stb, combinational.
- tick  out  1  one-clk pulse per prescaler period.
- ch_irq  out  NUM_CH  per channel: flag & irq_en.
- irq  out  1  OR of ch_irq.

Behaviour:
- Reset (rst=0, async) clears all state:
  - div_cnt=0, DIV=DIV0, CNT=0.
  - STATUS=0, IRQ_EN=0.
  - Every channel: RELOAD=0, RUN=0, PERIODIC=0, REMAIN=0.
  - tick, ch_irq and irq are 0. data_out is 0 because stb is low.
- Prescaler:
  - div_cnt counts 0..DIV-1 and wraps to 0.
  - tick=1 exactly in the cycle div_cnt==DIV-1, so the period is DIV clks.
  - A DIV write takes effect immediately and also clears div_cnt.
  - DIV value 0 is treated as 1, giving tick every clk.
- Tick counter: CNT increments on tick and wraps 2^CNT_W-1 -> 0. A CPU write in the same cycle as a tick wins: CNT=written value, no increment.
- Register map (word addr; unused addresses read 0, writes ignored):
  - 0 CNT, RW.
  - 1 STATUS: R = flags [NUM_CH-1:0]; W1C.
  - 2 IRQ_EN, RW, [NUM_CH-1:0].
  - 3 DIV, R; W only with the optional feature.
  - 8+4i RELOAD_i, RW.
  - 9+4i CTRL_i, RW: bit0 RUN, bit1 PERIODIC.
  - 10+4i REMAIN_i, R.
- Bus:
  - Reads are combinational in the same cycle as stb.
  - Writes commit on the clk edge with stb&we.
  - ack=stb, so there are no wait states.
- Channel FSM, states IDLE (RUN=0) and ARMED (RUN=1):
  - IDLE -> ARMED on a CTRL write with RUN=1: REMAIN<=max(RELOAD,1).
  - A CTRL write with RUN=1 while already ARMED re-arms the channel, reloading REMAIN. It only updates PERIODIC if that bit changed.
  - Any CTRL write with RUN=0 goes to IDLE; REMAIN holds its value.
  - ARMED on tick with REMAIN>1: REMAIN-1.
  - ARMED on tick with REMAIN==1: expiry. flag_i<=1, then:
    - periodic: REMAIN<=max(RELOAD,1), stay ARMED;
    - one-shot: REMAIN<=0, go to IDLE.
  - A RELOAD write while ARMED does not touch REMAIN; it applies at the next reload.
- Simultaneous events:
  - Expiry and W1C of the same flag in one cycle: set wins, flag stays 1.
  - CTRL write and tick in one cycle: the write wins; that tick is ignored for the channel.
- ch_irq and irq are combinational from the registered flag and IRQ_EN. They assert the cycle after the expiry edge and deassert the cycle after W1C.

Optional Feature:
- Macro: MS_TIMER_DIV_WR_EN.
- Defined: DIV is writable at addr 3 (data_in[DIV_W-1:0]) and the prescaler behaves as described above.
- Undefined: DIV is the constant DIV0, writes to addr 3 are ignored, reads return DIV0, and no DIV register is synthesised.

Decomposition:
- Shared package ms_timer_pkg holds:
  - register address constants: CNT, STATUS, IRQ_EN, DIV, CH_BASE=8, CH_STRIDE=4, and offsets RELOAD/CTRL/REMAIN;
  - CTRL bit positions RUN=0, PERIODIC=1;
  - the channel-state typedef {IDLE, ARMED}.
- Sub-module ms_timer_chan: one channel, instantiated NUM_CH times via generate. It holds RELOAD, CTRL, REMAIN and the FSM, and emits an expiry pulse. The top level keeps the prescaler, CNT, STATUS/IRQ_EN, address decode and read mux.

Test Plan (CLOCK_FREQ=10000, TICK_HZ=1000 -> DIV0=10, NUM_CH=4, CNT_W=32):
- Reset, then run 100 clks -> tick pulses 10 clks apart with the first at clk 10; CNT reads 10; irq=0.
- CH0: write RELOAD=3, then CTRL=0b01 (one-shot) -> flag0 sets on the 3rd tick; REMAIN=0; RUN=0. With IRQ_EN=1, irq asserts one clk after expiry; W1C STATUS=1 clears it.
- CH1: write RELOAD=2, then CTRL=0b11 (periodic) -> expiry every 2 ticks (20 clks) for ≥5 periods. A RELOAD=5 write mid-run takes effect after the current period.
- Same-cycle collisions:
  - W1C of flag2 coincident with CH2 expiry -> flag2 stays 1.
  - CNT write 0xFFFF_FFFF coincident with a tick -> CNT=0xFFFF_FFFF, then wraps to 0 on the next tick.
- Assert rst low for 1 clk mid-count with CH3 armed -> all registers zero immediately (async); ch_irq=0; prescaler restarts from 0.
- With MS_TIMER_DIV_WR_EN: write DIV=4 -> ticks every 4 clks from the write. Without it: the write is ignored and DIV reads 10.
